// File: rtl/sar_pkg.sv
// Shared types and sizing for the successive-approximation search.
// Imported by sar_search and sar_step.
package sar_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROBE,
    S_DONE
  } state_e;

  function automatic int probe_w(input int w);
    return $clog2(w + 1) + 1;
  endfunction

  localparam int SAR_WIDTH = 8;
  localparam int SAR_PW    = probe_w(SAR_WIDTH);

endpackage

// File: rtl/sar_step.sv
// One binary-search step: narrows [lo,hi] from a one-hot flag set
// and proposes the next midpoint.
module sar_step
  import sar_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] trial_i,
  input  logic             lt_i,
  input  logic             eq_i,
  input  logic             gt_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] trial_o,
  output logic             term_o,
  output logic             miss_o
);

  logic [WIDTH:0] sum;

  always_comb begin
    lo_o   = lo_i;
    hi_o   = hi_i;
    term_o = 1'b0;
    miss_o = 1'b0;
    unique case (1'b1)
      eq_i: term_o = 1'b1;
      lt_i: begin
        if (trial_i == lo_i) begin
          term_o = 1'b1;
          miss_o = 1'b1;
        end else begin
          hi_o = trial_i - 1'b1;
        end
      end
      gt_i: begin
        if (trial_i == hi_i) begin
          term_o = 1'b1;
          miss_o = 1'b1;
        end else begin
          lo_o = trial_i + 1'b1;
        end
      end
      default: ;
    endcase
    // midpoint at WIDTH+1 bits so lo+hi never overflows
    sum     = {1'b0, lo_o} + {1'b0, hi_o};
    trial_o = sum[WIDTH:1];
  end

endmodule

// File: rtl/sar_search.sv
// Binary search of a hidden target through an external comparator,
// one probe per clock.
module sar_search
  import sar_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int PW   = probe_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [WIDTH-1:0] trial,
  input  logic             cmp_lt,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [PW-1:0]    probes
);

  state_e state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] trial_q, trial_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [PW-1:0]    probes_q, probes_d;
  logic             found_q, found_d;
  logic             err_q, err_d;

  logic             onehot;
  logic [WIDTH-1:0] nlo, nhi, ntrial;
  logic             term, miss;

  assign onehot = ({cmp_lt, cmp_eq, cmp_gt} == 3'b100) ||
                  ({cmp_lt, cmp_eq, cmp_gt} == 3'b010) ||
                  ({cmp_lt, cmp_eq, cmp_gt} == 3'b001);

  // step only ever sees a clean one-hot set; bad flags are caught here
  sar_step #(.WIDTH(WIDTH)) u_step (
    .lo_i   (lo_q),
    .hi_i   (hi_q),
    .trial_i(trial_q),
    .lt_i   (cmp_lt & onehot),
    .eq_i   (cmp_eq & onehot),
    .gt_i   (cmp_gt & onehot),
    .lo_o   (nlo),
    .hi_o   (nhi),
    .trial_o(ntrial),
    .term_o (term),
    .miss_o (miss)
  );

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    trial_d  = trial_q;
    result_d = result_q;
    probes_d = probes_q;
    found_d  = found_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (!abort && start) begin
          lo_d     = '0;
          hi_d     = '1;
          trial_d  = {1'b0, {(WIDTH-1){1'b1}}};
          probes_d = PW'(1);
          found_d  = 1'b0;
          err_d    = 1'b0;
          result_d = '0;
          state_d  = S_PROBE;
        end
      end
      S_PROBE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!onehot) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = S_DONE;
        end else if (term) begin
          found_d = !miss;
          if (cmp_eq) result_d = trial_q;
          state_d = S_DONE;
        end else if (probes_q == PW'(WIDTH + 1)) begin
          err_d   = 1'b1;
          found_d = 1'b0;
          state_d = S_DONE;
        end else begin
          lo_d     = nlo;
          hi_d     = nhi;
          trial_d  = ntrial;
          probes_d = probes_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lo_q     <= '0;
      hi_q     <= '1;
      trial_q  <= '0;
      result_q <= '0;
      probes_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      trial_q  <= trial_d;
      result_q <= result_d;
      probes_q <= probes_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  assign trial  = trial_q;
  assign result = result_q;
  assign probes = probes_q;
  assign found  = found_q;
  assign err    = err_q;
  assign busy   = (state_q == S_PROBE);
  assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_sar_search.sv
// Directed bench for sar_search: comparator model on a target
// register, trial sequence checked every probe cycle.
module tb_sar_search;
  import sar_pkg::*;

  localparam int W  = 8;
  localparam int PW = probe_w(W);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  trial;
  logic          cmp_lt, cmp_eq, cmp_gt;
  logic          busy, done, found, err;
  logic [W-1:0]  result;
  logic [PW-1:0] probes;

  logic [W-1:0]  target = '0;
  int            fmode = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            exp_q[$];

  always #5 clk = ~clk;

  sar_search #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .trial (trial),
    .cmp_lt(cmp_lt),
    .cmp_eq(cmp_eq),
    .cmp_gt(cmp_gt),
    .busy  (busy),
    .done  (done),
    .found (found),
    .err   (err),
    .result(result),
    .probes(probes)
  );

  // comparator: A = target, B = trial; fmode 1 = lt+gt, 2 = stuck gt
  always_comb begin
    cmp_lt = (target < trial);
    cmp_eq = (target == trial);
    cmp_gt = (target > trial);
    if (fmode == 1) begin
      cmp_lt = 1'b1;
      cmp_eq = 1'b0;
      cmp_gt = 1'b1;
    end else if (fmode == 2) begin
      cmp_lt = 1'b0;
      cmp_eq = 1'b0;
      cmp_gt = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".trial"}, trial, 0);
    chk({tag, ".result"}, result, 0);
    chk({tag, ".probes"}, probes, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".found"}, found, 0);
    chk({tag, ".err"}, err, 0);
  endtask

  // called at a negedge; start is raised immediately
  task automatic search(input string tag, input int tgt, input int fm,
                        input int fat, input bit xf, input bit xe,
                        input int xr);
    target = W'(tgt);
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    foreach (exp_q[i]) begin
      chk($sformatf("%s.trial%0d", tag, i), trial, exp_q[i]);
      chk($sformatf("%s.probes%0d", tag, i), probes, i + 1);
      chk($sformatf("%s.busy%0d", tag, i), busy, 1);
      chk($sformatf("%s.nodone%0d", tag, i), done, 0);
      if (fm == 2) fmode = 2;
      else fmode = (fm == 1 && i == fat) ? 1 : 0;
      start = (i == 1);
      @(negedge clk);
    end
    start = 1'b0;
    fmode = 0;
    chk({tag, ".done"}, done, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".found"}, found, xf);
    chk({tag, ".err"}, err, xe);
    chk({tag, ".result"}, result, xr);
    chk({tag, ".probes"}, probes, exp_q.size());
    @(negedge clk);
    chk({tag, ".pulse"}, done, 0);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".hold"}, found, xf);
  endtask

  initial begin
    #12;
    chk_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;

    exp_q = '{127, 191, 223, 207, 199, 203, 201, 200};
    search("t200", 200, 0, 0, 1, 0, 200);

    exp_q = '{127, 63, 31, 15, 7, 3, 1, 0};
    search("t0", 0, 0, 0, 1, 0, 0);

    exp_q = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    search("t255", 255, 0, 0, 1, 0, 255);

    exp_q = '{127, 63, 95};
    search("badflags", 100, 1, 2, 0, 1, 0);

    exp_q = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    search("stuckgt", 0, 2, 0, 0, 0, 0);

    // abort on the 4th probe
    target = 8'd200;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    exp_q  = '{127, 191, 223, 207};
    foreach (exp_q[i]) begin
      chk($sformatf("abt.trial%0d", i), trial, exp_q[i]);
      abort = (i == 3);
      @(negedge clk);
    end
    abort = 1'b0;
    chk("abt.busy", busy, 0);
    chk("abt.done", done, 0);
    chk("abt.found", found, 0);
    chk("abt.err", err, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("abt.nodone%0d", k), done, 0);
      chk($sformatf("abt.nobusy%0d", k), busy, 0);
    end

    // start with abort in IDLE stays IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("both.busy", busy, 0);
    chk("both.probes", probes, 4);

    // reset mid-search
    target = 8'd200;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid.busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    chk_reset_vals("midrst2");
    rst_n = 1'b1;

    exp_q = '{127, 63, 31, 15, 7, 3, 1, 0};
    search("post", 0, 0, 0, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
